// File: rtl/lu_pkg.sv
// lu_pkg: shared types and helpers for the lu_recompose engine.
// Holds the FSM state encoding, the triangular storage sizing/indexing
// functions and the signed saturation limits used when LU_SAT_EN is defined.
package lu_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // Number of strictly-lower L entries for a dim x dim matrix.
    function automatic int unsigned nl_f(input int unsigned dim);
        return (dim * (dim - 32'd1)) / 32'd2;
    endfunction

    // Number of upper-triangular U entries (diagonal included).
    function automatic int unsigned nu_f(input int unsigned dim);
        return (dim * (dim + 32'd1)) / 32'd2;
    endfunction

    // Flat index of L[i][k] (k < i) in row-major strictly-lower order.
    function automatic int unsigned l_idx_f(input int unsigned i, input int unsigned k);
        return ((i * (i - 32'd1)) / 32'd2) + k;
    endfunction

    // Flat index of U[k][j] (j >= k) in row-major upper order.
    function automatic int unsigned u_idx_f(input int unsigned dim, input int unsigned k,
                                            input int unsigned j);
        return (k * dim) - ((k * (k - 32'd1)) / 32'd2) + (j - k);
    endfunction

    // Largest signed value representable in w bits (w <= 64).
    function automatic logic [63:0] sat_max_f(input int unsigned w);
        return (64'd1 << (w - 32'd1)) - 64'd1;
    endfunction

    // Smallest signed value representable in w bits; low w bits are 100..0.
    function automatic logic [63:0] sat_min_f(input int unsigned w);
        return ~sat_max_f(w);
    endfunction

endpackage

// File: rtl/lu_recompose_if.sv
// lu_recompose_if: input word stream and output A-element stream of the
// recomposition engine. master = producer/consumer side, slave = engine.
interface lu_recompose_if #(
    parameter int iSZ = 8,
    parameter int oSZ = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [iSZ-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [oSZ-1:0] out_data;
    logic           out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/lu_mac.sv
// lu_mac: signed multiply-accumulate for one A element.
// clr_i restarts the sum from the current product; en_i commits the step.
// acc_nxt_o is the post-step value so the caller can capture the final
// element in the same cycle as the last MAC.
// Define LU_SAT_EN for sticky per-element saturation; otherwise wraps.
module lu_mac
    import lu_pkg::*;
#(
    parameter int iSZ = 8,
    parameter int oSZ = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic signed [iSZ-1:0] a_i,
    input  logic signed [iSZ-1:0] b_i,
    output logic signed [oSZ-1:0] acc_nxt_o
);

    logic signed [2*iSZ-1:0] prod_s;
    logic signed [oSZ-1:0]   prod_ext_s;
    logic signed [oSZ-1:0]   base_s;
    logic signed [oSZ-1:0]   acc_q;
    logic signed [oSZ-1:0]   acc_d;

    // Full-precision product, then sign-extend or truncate to the accumulator width.
    assign prod_s     = (2*iSZ)'(a_i) * (2*iSZ)'(b_i);
    assign prod_ext_s = oSZ'(prod_s);
    assign base_s     = clr_i ? '0 : acc_q;
    assign acc_nxt_o  = acc_d;

`ifdef LU_SAT_EN
    localparam logic [oSZ-1:0] SAT_MAX = oSZ'(sat_max_f(oSZ));
    localparam logic [oSZ-1:0] SAT_MIN = oSZ'(sat_min_f(oSZ));

    logic [oSZ:0] sum_s;
    logic         sat_q;
    logic         sat_d;
    logic         hold_s;
    logic         ovf_s;

    assign sum_s  = {base_s[oSZ-1], base_s} + {prod_ext_s[oSZ-1], prod_ext_s};
    assign ovf_s  = sum_s[oSZ] ^ sum_s[oSZ-1];
    assign hold_s = sat_q & ~clr_i;

    // Saturating step: once an element has clipped it stays at the limit.
    always_comb begin
        acc_d = sum_s[oSZ-1:0];
        sat_d = 1'b0;
        if (hold_s) begin
            acc_d = acc_q;
            sat_d = 1'b1;
        end else if (ovf_s) begin
            acc_d = sum_s[oSZ] ? SAT_MIN : SAT_MAX;
            sat_d = 1'b1;
        end else begin
            acc_d = sum_s[oSZ-1:0];
            sat_d = 1'b0;
        end
    end

    // Sticky saturation flag, restarted with each new element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (en_i) begin
            sat_q <= sat_d;
        end
    end
`else
    // Wrap-around step: modulo 2^oSZ accumulation.
    always_comb begin
        acc_d = base_s + prod_ext_s;
    end
`endif

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/lu_recompose.sv
// lu_recompose: rebuilds A = L*U from the factor streams of the LU array.
// Loads strictly-lower L (unit diagonal implied) then upper U, computes each
// A[i][j] with one sequential MAC and streams A out row-major.
// Optional macro LU_SAT_EN (handled inside lu_mac) selects saturating arithmetic.
module lu_recompose
    import lu_pkg::*;
#(
    parameter int iSZ = 8,
    parameter int oSZ = 16,
    parameter int DIM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lu_recompose_if.slave bus,
    output logic          busy
);

    localparam int NL  = int'(nl_f(DIM));
    localparam int NU  = int'(nu_f(DIM));
    localparam int NT  = NL + NU;
    localparam int CW  = $clog2(NT);
    localparam int IW  = $clog2(DIM);
    localparam int LIW = (NL > 1) ? $clog2(NL) : 1;
    localparam int UIW = $clog2(NU);

    state_e state_q, state_d;

    logic signed [iSZ-1:0] l_q [NL];
    logic signed [iSZ-1:0] u_q [NU];
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         i_q, j_q, k_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [oSZ-1:0]        out_data_q;
    logic                  busy_q;

    logic                  load_fire_s;
    logic                  last_load_s;
    logic [IW-1:0]         min_s;
    logic                  mac_last_s;
    logic                  last_elem_s;
    logic                  out_fire_s;
    logic signed [iSZ-1:0] l_op_s;
    logic signed [iSZ-1:0] u_op_s;
    logic signed [oSZ-1:0] acc_nxt_s;

    assign load_fire_s = bus.in_valid && in_ready_q;
    assign last_load_s = (cnt_q == CW'(NT - 1));
    assign min_s       = (i_q < j_q) ? i_q : j_q;
    assign mac_last_s  = (k_q == min_s);
    assign last_elem_s = (i_q == IW'(DIM - 1)) && (j_q == IW'(DIM - 1));
    assign out_fire_s  = out_valid_q && bus.out_ready;

    // Operand select: the implied unit diagonal of L stands in for L[i][i].
    always_comb begin
        l_op_s = '0;
        if (k_q == i_q) begin
            l_op_s = {{(iSZ-1){1'b0}}, 1'b1};
        end else if (l_idx_f(32'(i_q), 32'(k_q)) < NL) begin
            l_op_s = l_q[LIW'(l_idx_f(32'(i_q), 32'(k_q)))];
        end else begin
            l_op_s = '0;
        end
    end

    assign u_op_s = u_q[UIW'(u_idx_f(DIM, 32'(k_q), 32'(j_q)))];

    lu_mac #(
        .iSZ (iSZ),
        .oSZ (oSZ)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (k_q == '0),
        .en_i      (state_q == COMPUTE),
        .a_i       (l_op_s),
        .b_i       (u_op_s),
        .acc_nxt_o (acc_nxt_s)
    );

    // Next-state logic: LOAD -> COMPUTE -> OUTPUT -> (COMPUTE | LOAD).
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (load_fire_s && last_load_s) begin
                    state_d = COMPUTE;
                end else begin
                    state_d = LOAD;
                end
            end
            COMPUTE: begin
                if (mac_last_s) begin
                    state_d = OUTPUT;
                end else begin
                    state_d = COMPUTE;
                end
            end
            OUTPUT: begin
                if (out_fire_s) begin
                    state_d = last_elem_s ? LOAD : COMPUTE;
                end else begin
                    state_d = OUTPUT;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: factor storage, element counters and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NL; n++) l_q[n] <= '0;
            for (int n = 0; n < NU; n++) u_q[n] <= '0;
            cnt_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q <= (state_d == LOAD);
            busy_q     <= (state_d != LOAD);
            case (state_q)
                LOAD: begin
                    if (load_fire_s) begin
                        if (cnt_q < CW'(NL)) begin
                            l_q[LIW'(cnt_q)] <= $signed(bus.in_data);
                        end else begin
                            u_q[UIW'(cnt_q - CW'(NL))] <= $signed(bus.in_data);
                        end
                        if (last_load_s) begin
                            cnt_q <= '0;
                            i_q   <= '0;
                            j_q   <= '0;
                            k_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (mac_last_s) begin
                        out_data_q  <= acc_nxt_s;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_elem_s;
                    end else begin
                        k_q <= k_q + IW'(1);
                    end
                end
                OUTPUT: begin
                    if (out_fire_s) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        k_q         <= '0;
                        if (last_elem_s) begin
                            i_q <= '0;
                            j_q <= '0;
                        end else if (j_q == IW'(DIM - 1)) begin
                            i_q <= i_q + IW'(1);
                            j_q <= '0;
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;

endmodule

// File: doc/lu_recompose.md
Name: lu_recompose

Overview:
- Recomposition engine and the inverse of the LU factorization array: rebuilds A = L*U from the factor streams the array emits.
- Loads the strictly-lower L entries (unit diagonal implied, Doolittle form) and the upper-triangular U entries.
- Computes each A element with a single sequential MAC and streams A out row-major over a valid/ready handshake.
- Sits after the systolic array as the self-check / reconstruction stage.

Parameters:
- iSZ, 8, width of the signed two's-complement L/U input words.
- oSZ, 16, width of the signed A output words and the accumulator.
- DIM, 4, matrix order; supported range 2..8.

Ports:
- clk  input  1  single clock; rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  an input word is present.
- in_ready  output  1  block accepts an input word (LOAD state only).
- in_data  input  iSZ  L/U element in load order.
- out_valid  output  1  an A element is presented.
- out_ready  input  1  consumer accepts the A element.
- out_data  output  oSZ  A[i][j].
- out_last  output  1  marks A[DIM-1][DIM-1].
- busy  output  1  high in COMPUTE or OUTPUT.

Behaviour:
- Reset: async on rst_n low. State=LOAD; all counters and L/U storage cleared; in_ready=0 during reset, then 1 from the first clock after release. out_valid=0, out_data=0, out_last=0, busy=0. A reset mid-operation discards all data and any pending output.
- LOAD: a word transfers on in_valid&&in_ready.
  - First NL=DIM*(DIM-1)/2 words fill L row-major, strictly lower (L10,L20,L21,L30,...).
  - Next NU=DIM*(DIM+1)/2 words fill U row-major, upper incl. diagonal (U00,U01,...,U0n,U11,...).
  - The cycle after the last transfer: state=COMPUTE, in_ready=0.
- COMPUTE for element (i,j):
  - acc cleared; k steps 0..min(i,j), one MAC per cycle.
  - Product is L[i][k]*U[k][j], iSZ x iSZ signed, full 2*iSZ product, sign-extended or truncated to oSZ.
  - L[i][i] is treated as 1, and k=i contributes U[i][j]. Entries above the diagonal are zero and never visited.
  - Element (i,j) takes min(i,j)+1 cycles. After the final MAC, out_data<=acc, out_valid<=1, state=OUTPUT.
- OUTPUT: out_data/out_valid/out_last are held stable until out_ready.
  - On out_valid&&out_ready with more elements remaining: advance (i,j) row-major and return to COMPUTE next cycle; out_valid drops for at least 1 cycle.
  - On the last element: out_last=1; after the handshake state=LOAD and in_ready=1 next cycle.
- Accumulation wraps modulo 2^oSZ by default.
- in_valid is ignored outside LOAD. out_ready is ignored when out_valid=0.

Optional Feature:
- LU_SAT_EN defined: every accumulate step saturates to the signed oSZ range [-2^(oSZ-1), 2^(oSZ-1)-1]; the saturation is sticky per element.
- Undefined: wrap-around arithmetic as above.
- Latency is identical either way.

Decomposition:
- Package lu_pkg holds:
  - state enum {LOAD, COMPUTE, OUTPUT};
  - functions for NL, NU and storage index from (i,k)/(k,j);
  - the saturation limits.
- One natural sub-module, lu_mac: signed multiply-accumulate with clear, enable, and the LU_SAT_EN saturation logic.

Test Plan:
- Identity: L all 0; U diagonal=1, rest 0. Expect 16 words row-major = I, out_last only on word 16, zero backpressure.
- Upper passthrough:
  - Stimulus: L all 0; U row0 = 1,2,3,4; U11..U13 = 5,6,7; U22=8; U23=9; U33=10.
  - Expect row1 = 0,5,6,7 and row3 = 0,0,0,10.
  - Modification: set L10=2 → expect row1 = 2,9,12,15.
- Signed: L10=8'hFF (-1), U00=8'h80 (-128), rest 0 → expect A10=16'h0080 and A00=16'hFF80.
- Overflow:
  - Stimulus: L30=L31=L32=127; U03=U13=U23=U33=127; rest 0.
  - Without LU_SAT_EN: A33=16'hBD82 (48514 wrapped).
  - With LU_SAT_EN: A33=16'h7FFF.
- Backpressure: hold out_ready=0 for 5 cycles on A12 → out_data/out_valid stable throughout; no element skipped or duplicated; count of 16 intact.
- Reset mid-LOAD: after 7 of 16 words, pulse rst_n low → outputs zero, in_ready=1 after release; a fresh 16-word load yields the correct result.
